plab4_net_router_output_ctrl_tp: RTL

PLAB4_NET_ROUTER_OUTPUT_CTRL_TP -- requirements
Module: plab4_net_router_output_ctrl_tp

---
 rtl/plab4_net_router_output_ctrl_tp_pkg.sv | 40 ++++
 rtl/plab4_net_rr_arb3.sv | 32 +++
 rtl/plab4_net_router_output_ctrl_tp.sv | 61 ++++++
 3 files changed

// File: rtl/plab4_net_router_output_ctrl_tp_pkg.sv
// Shared plab4-net router ctrl definitions: port indices and small
// arbitration/encoding helpers used by the output ctrl and the input ctrls.
package plab4_net_router_output_ctrl_tp_pkg;

  localparam int unsigned PREV = 0;
  localparam int unsigned TERM = 1;
  localparam int unsigned NEXT = 2;

  localparam int unsigned NUM_PORTS = 3;

  typedef logic [NUM_PORTS-1:0] port_vec_t;
  typedef logic [1:0]           port_sel_t;

  // Round-robin pick: first requester at or after the one-hot prio
  // position, scanning prev -> term -> next cyclically.
  function automatic port_vec_t rr_pick(input port_vec_t reqs, input port_vec_t prio);
    port_vec_t pick;
    logic      found;
    logic [1:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int s = 0; s < NUM_PORTS; s++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = 2'((s + k) % NUM_PORTS);
        if (prio[s] && !found && reqs[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic port_sel_t onehot_to_sel(input port_vec_t grants);
    if (grants[NEXT]) return port_sel_t'(NEXT);
    if (grants[TERM]) return port_sel_t'(TERM);
    return port_sel_t'(PREV);
  endfunction

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// Three-way round-robin arbiter with a grant enable; grants are combinational
// from reqs, and the priority pointer advances past each winner.
module plab4_net_rr_arb3
  import plab4_net_router_output_ctrl_tp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] reqs,
  output logic [2:0] grants
);

  port_vec_t prio;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grants = '0;
    if (en) grants = rr_pick(reqs, prio);
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 3'b001;
    end else if (|grants) begin
      prio <= {grants[1:0], grants[2]};
    end
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl_tp.sv
// Router output ctrl with time-partitioned scheduling: two security domains
// alternate fixed slots, each ending in dead cycles; traffic never shifts slots.
module plab4_net_router_output_ctrl_tp
  import plab4_net_router_output_ctrl_tp_pkg::*;
#(
  parameter int p_slot_cycles = 4,
  parameter int p_dead_cycles = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] reqs,
  output logic [2:0] grants,
  output logic [1:0] sel,
  output logic       out_val,
  input  logic       out_rdy,
  output logic       domain0,
  output logic       domain1
);

  localparam int CW = $clog2(p_slot_cycles);
  localparam logic [CW-1:0] LAST_CNT   = CW'(p_slot_cycles - 1);
  localparam logic [CW-1:0] DEAD_START = CW'(p_slot_cycles - p_dead_cycles);

  logic [CW-1:0] cnt;
  logic          cur_dom;
  logic          dead;
  logic          grant_en;

  // Slot timing depends only on the clock, never on grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      cur_dom <= 1'b0;
    end else if (cnt == LAST_CNT) begin
      cnt     <= '0;
      cur_dom <= ~cur_dom;
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

  assign dead = (cnt >= DEAD_START);

  // NOTE: reset also gates the combinational outputs so they drop the moment
  // reset falls, not at the next clock edge.
  assign grant_en = out_rdy & ~dead & reset;
  assign domain0  = reset & ~cur_dom & ~dead;
  assign domain1  = reset &  cur_dom & ~dead;

  plab4_net_rr_arb3 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (grant_en),
    .reqs   (reqs),
    .grants (grants)
  );

  assign sel     = onehot_to_sel(grants);
  assign out_val = |grants;

endmodule
